register_scoreboard: RTL
========================

Name: register_scoreboard

Overview:
- Tracks in-flight writes to the 32 architectural registers between the issue/decode stage and writeback.
- Writeback is the same interface that drives the register file write port.
- Tells decode when a source operand read from the register file would be stale, and asserts STALL until the producing write has landed.
- Acts as the read-side hazard counterpart to the register file's write port. It sits beside register_file in decode.

Parameters:
MAX_INFLIGHT, 3, maximum outstanding writes tracked per register; the counter width is clog2(MAX_INFLIGHT+1).
WB_BYPASS, 0, 1 means a writeback in the same cycle releases a hazard on the register it writes (register file is write-first); 0 means no same-cycle release.

Ports:
CLK  input  1  clock; all state updates on posedge
RST  input  1  synchronous, active-high reset
ISSUE_Valid  input  1  decode presents an instruction this cycle
ISSUE_Rs1  input  5  source register 1 address
ISSUE_Rs2  input  5  source register 2 address
ISSUE_Uses_Rs1  input  1  instruction reads Rs1
ISSUE_Uses_Rs2  input  1  instruction reads Rs2
ISSUE_Writes_Rd  input  1  instruction will write Rd
ISSUE_Rd  input  5  destination register address
REG_W_En  input  1  writeback write enable (same signal as register file)
REG_W_Addr  input  5  writeback destination address
KILL_Valid  input  1  a previously issued writing instruction was squashed and will never write back
KILL_Addr  input  5  Rd of the squashed instruction
STALL  output  1  combinational; decode must hold its instruction
ISSUE_Accept  output  1  ISSUE_Valid & ~STALL
BUSY  output  32  bit i set when counter i is nonzero; bit 0 is always 0
INFLIGHT_Total  output  7  sum of all counters
ERR  output  1  sticky underflow flag

Behaviour:
- Reset: every counter cleared to 0; outputs take BUSY=0, INFLIGHT_Total=0, ERR=0, STALL=0.
- Per-register count cnt[i], i=1..31. x0 has no counter: it is never busy, never stalls, and writes/kills to it are ignored.
- A source hazard hzN is true when ISSUE_Uses_RsN, RsN≠0, and cnt[RsN]>0.
  - With WB_BYPASS=1, hzN is false when cnt[RsN]==1, REG_W_En=1 and REG_W_Addr==RsN.
- Rd saturation is true when ISSUE_Writes_Rd, Rd≠0 and cnt[Rd]==MAX_INFLIGHT. A writeback or kill in the same cycle does not release saturation.
- STALL = ISSUE_Valid & (hz1 | hz2 | saturation). STALL is purely combinational from state and inputs; zero-cycle latency.
- Counter update per cycle, for each register i≠0:
  - inc = ISSUE_Accept & ISSUE_Writes_Rd & (ISSUE_Rd==i)
  - dec_w = REG_W_En & (REG_W_Addr==i)
  - dec_k = KILL_Valid & (KILL_Addr==i)
  - next = cnt + inc − dec_w − dec_k
- Simultaneous events:
  - An issue and a writeback to the same register leave the count unchanged.
  - A writeback and a kill to the same register decrement by 2.
- Underflow: if any decrement would take a count below 0, the count clamps to 0 and ERR sets. ERR stays set until RST.
- Overflow cannot occur; saturation stalls the issue instead.
- INFLIGHT_Total and BUSY are registered views of the counters; they update one cycle after the event.
- Reset mid-operation: all counts return to 0 on the next edge regardless of other inputs. RST has priority over issue, writeback and kill.
- ISSUE_Valid=0 produces no stall and no increment, regardless of the Rs/Rd fields.

Test Plan:
1. Reset with random inputs held for 2 cycles -> BUSY=0, INFLIGHT_Total=0, ERR=0; with ISSUE_Valid=0, STALL=0.
2. Issue writing x5, then a reader of Rs1=x5 -> STALL=1 every cycle until REG_W_En with REG_W_Addr=5.
   - WB_BYPASS=0: STALL falls the cycle after the writeback.
   - WB_BYPASS=1: STALL falls in the writeback cycle.
   - BUSY[5] returns to 0.
3. Issue writing x0, then a reader of x0 -> STALL=0, BUSY=0, INFLIGHT_Total=0.
4. Three issues writing x31 (MAX_INFLIGHT=3) -> a fourth issue writing x31 stalls. One writeback to x31 -> the fourth is accepted on the next cycle; cnt stays at 3, INFLIGHT_Total=3.
5. Issue writing x7 in the same cycle as a writeback to x7 while cnt[7]=1 -> cnt[7] stays 1. Then KILL_Addr=7 -> BUSY[7]=0.
6. Writeback to x9 with cnt[9]=0 -> ERR=1 and stays 1 until RST; cnt[9]=0.

Source files
------------

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register in-flight write counters that flag stale source operands
// and saturated destinations so decode can stall until the producing write lands.
module register_scoreboard #(
   parameter int MAX_INFLIGHT = 3,
   parameter bit WB_BYPASS    = 1'b0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ISSUE_Valid,
   input  logic [4:0]  ISSUE_Rs1,
   input  logic [4:0]  ISSUE_Rs2,
   input  logic        ISSUE_Uses_Rs1,
   input  logic        ISSUE_Uses_Rs2,
   input  logic        ISSUE_Writes_Rd,
   input  logic [4:0]  ISSUE_Rd,
   input  logic        REG_W_En,
   input  logic [4:0]  REG_W_Addr,
   input  logic        KILL_Valid,
   input  logic [4:0]  KILL_Addr,
   output logic        STALL,
   output logic        ISSUE_Accept,
   output logic [31:0] BUSY,
   output logic [6:0]  INFLIGHT_Total,
   output logic        ERR
);
   localparam int CW  = $clog2(MAX_INFLIGHT + 1);
   localparam int CW1 = CW + 1;
   logic [CW-1:0] cnt_q [32];
   logic [CW-1:0] cnt_d [32];
   logic [31:0]   busy_q, busy_d;
   logic [6:0]    total_q, total_d;
   logic          err_q, err_d;
   logic [CW:0]   sum, dec;
   logic          hz1, hz2, sat;
   // a writeback landing this cycle only clears the hazard when the register file is write-first
   assign hz1 = ISSUE_Uses_Rs1 && ISSUE_Rs1 != 5'd0 && cnt_q[ISSUE_Rs1] != '0 &&
                !(WB_BYPASS && cnt_q[ISSUE_Rs1] == CW'(1) && REG_W_En && REG_W_Addr == ISSUE_Rs1);
   assign hz2 = ISSUE_Uses_Rs2 && ISSUE_Rs2 != 5'd0 && cnt_q[ISSUE_Rs2] != '0 &&
                !(WB_BYPASS && cnt_q[ISSUE_Rs2] == CW'(1) && REG_W_En && REG_W_Addr == ISSUE_Rs2);
   assign sat = ISSUE_Writes_Rd && ISSUE_Rd != 5'd0 && cnt_q[ISSUE_Rd] == CW'(MAX_INFLIGHT);
   assign STALL          = ISSUE_Valid & (hz1 | hz2 | sat);
   assign ISSUE_Accept   = ISSUE_Valid & ~STALL;
   assign BUSY           = busy_q;
   assign INFLIGHT_Total = total_q;
   assign ERR            = err_q;
   always_comb begin
      cnt_d    = cnt_q;
      cnt_d[0] = '0;
      busy_d   = '0;
      total_d  = '0;
      err_d    = err_q;
      sum      = '0;
      dec      = '0;
      for (int i = 1; i < 32; i++) begin
         sum      = {1'b0, cnt_q[i]} + CW1'(ISSUE_Accept && ISSUE_Writes_Rd && ISSUE_Rd == 5'(i));
         dec      = CW1'(REG_W_En && REG_W_Addr == 5'(i)) + CW1'(KILL_Valid && KILL_Addr == 5'(i));
         err_d    = err_d | (dec > sum);
         cnt_d[i] = dec > sum ? '0 : CW'(sum - dec);
         busy_d[i] = cnt_d[i] != '0;
         total_d  = total_d + 7'(cnt_d[i]);
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
         busy_q  <= '0;
         total_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         total_q <= total_d;
         err_q   <= err_d;
      end
   end
endmodule
